// File: rtl/alu_issue_ctrl_if.sv
// Request / ALU / response signal bundle for the ALU issue controller.
// The master modport is the controller's view; the slave modport is the surrounding environment's view.
interface alu_issue_ctrl_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_src1;
    logic [DATA_W-1:0] req_src2;
    logic [1:0]        req_aluop;
    logic [5:0]        req_funct;
    logic [TAG_W-1:0]  req_tag;

    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    logic [CNT_W-1:0]  occupancy;

    modport master (
        input  req_valid, req_src1, req_src2, req_aluop, req_funct, req_tag,
        output req_ready,
        output alu_src1, alu_src2, alu_ctrl,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err,
        input  rsp_ready,
        output occupancy
    );

    modport slave (
        output req_valid, req_src1, req_src2, req_aluop, req_funct, req_tag,
        input  req_ready,
        input  alu_src1, alu_src2, alu_ctrl,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err,
        output rsp_ready,
        input  occupancy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ALUOp/funct at push, queues requests in an in-order FIFO,
// drives the combinational ALU from the FIFO head and captures its result into a backpressured response register.
module alu_issue_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.master bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    localparam logic [CTRL_W-1:0] CTRL_AND = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] CTRL_OR  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] CTRL_SUB = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] CTRL_SLT = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] CTRL_MUL = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] CTRL_XOR = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] CTRL_NOR = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] CTRL_ILL = CTRL_W'(15);

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [CTRL_W-1:0] ctrl;
        logic              err;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_err;
    entry_t            push_entry;
    entry_t            head;
    logic              not_empty;
    logic              not_full;
    logic              push;
    logic              pop;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic              rsp_err_q;

    // ALUOp / funct decode into the ALU control code
    always_comb begin
        dec_ctrl = CTRL_ILL;
        dec_err  = 1'b0;
        case (bus.req_aluop)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b11: dec_ctrl = CTRL_SLT;
            default: begin
                case (bus.req_funct)
                    6'b100000: dec_ctrl = CTRL_ADD;
                    6'b100010: dec_ctrl = CTRL_SUB;
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b101010: dec_ctrl = CTRL_SLT;
                    6'b011000: dec_ctrl = CTRL_MUL;
                    6'b100110: dec_ctrl = CTRL_XOR;
                    6'b100111: dec_ctrl = CTRL_NOR;
                    default: begin
                        dec_ctrl = CTRL_ILL;
                        dec_err  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        push_entry.src1 = bus.req_src1;
        push_entry.src2 = bus.req_src2;
        push_entry.ctrl = dec_ctrl;
        push_entry.err  = dec_err;
        push_entry.tag  = bus.req_tag;
    end

    // A full FIFO refuses pushes even when the head drains in the same cycle
    assign not_empty = (count != '0);
    assign not_full  = (count < CNT_W'(DEPTH));
    assign push      = bus.req_valid && not_full;
    assign pop       = not_empty && (!rsp_valid_q || bus.rsp_ready);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Response register captures the ALU output for the head being popped
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else if (pop) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= bus.alu_result;
            rsp_zero_q   <= bus.alu_zero;
            rsp_tag_q    <= head.tag;
            rsp_err_q    <= head.err;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    // Idle ALU inputs are parked at zero operands and the illegal code
    always_comb begin
        bus.alu_src1 = '0;
        bus.alu_src2 = '0;
        bus.alu_ctrl = CTRL_ILL;
        if (not_empty) begin
            bus.alu_src1 = head.src1;
            bus.alu_src2 = head.src2;
            bus.alu_ctrl = head.ctrl;
        end
    end

    assign bus.req_ready  = not_full;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.occupancy  = count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an attached behavioural ALU and an in-order response scoreboard.
module tb_alu_issue_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [31:0]      result;
        logic             zero;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [5:0] funct_tbl [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b101010, 6'b011000, 6'b100110, 6'b100111, 6'b000011};

    alu_issue_ctrl_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Project ALU behaviour: unknown codes (incl. 15) return zero
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl)
            4'd0:  alu_res = bus.alu_src1 & bus.alu_src2;
            4'd1:  alu_res = bus.alu_src1 | bus.alu_src2;
            4'd2:  alu_res = bus.alu_src1 + bus.alu_src2;
            4'd6:  alu_res = bus.alu_src1 - bus.alu_src2;
            4'd7:  alu_res = (bus.alu_src1 < bus.alu_src2) ? 32'd1 : 32'd0;
            4'd8:  alu_res = 32'(bus.alu_src1 * bus.alu_src2);
            4'd9:  alu_res = bus.alu_src1 ^ bus.alu_src2;
            4'd12: alu_res = ~(bus.alu_src1 | bus.alu_src2);
            default: alu_res = '0;
        endcase
        bus.alu_result = alu_res;
        bus.alu_zero   = (alu_res == 32'd0);
    end

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t        e;
        logic [31:0] r;
        logic        er;
        r  = '0;
        er = 1'b0;
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b11: r = (a < b) ? 32'd1 : 32'd0;
            default: begin
                case (f)
                    6'b100000: r = a + b;
                    6'b100010: r = a - b;
                    6'b100100: r = a & b;
                    6'b100101: r = a | b;
                    6'b101010: r = (a < b) ? 32'd1 : 32'd0;
                    6'b011000: r = 32'(a * b);
                    6'b100110: r = a ^ b;
                    6'b100111: r = ~(a | b);
                    default:   er = 1'b1;
                endcase
            end
        endcase
        e.result = r;
        e.zero   = (r == 32'd0);
        e.tag    = tag;
        e.err    = er;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Response monitor: handshakes are sampled mid-cycle, before the completing edge
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            exp_t e;
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL rsp_unexpected: observed tag %0h expected no response", bus.rsp_tag);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_result", bus.rsp_result, e.result);
                chk("rsp_zero",   32'(bus.rsp_zero), 32'(e.zero));
                chk("rsp_tag",    32'(bus.rsp_tag),  32'(e.tag));
                chk("rsp_err",    32'(bus.rsp_err),  32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag, output bit acc);
        bus.req_valid = 1'b1;
        bus.req_aluop = op;
        bus.req_funct = f;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_tag   = tag;
        acc = (bus.req_ready === 1'b1) && !rst;
        if (acc) sb.push_back(model(op, f, a, b, tag));
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || bus.rsp_valid === 1'b1) && cyc < 60) begin
            tick();
            cyc++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
        chk({pfx, "_rsp_result"}, bus.rsp_result,      32'd0);
        chk({pfx, "_rsp_zero"},   32'(bus.rsp_zero),   32'd0);
        chk({pfx, "_rsp_tag"},    32'(bus.rsp_tag),    32'd0);
        chk({pfx, "_rsp_err"},    32'(bus.rsp_err),    32'd0);
        chk({pfx, "_occupancy"},  32'(bus.occupancy),  32'd0);
        chk({pfx, "_req_ready"},  32'(bus.req_ready),  32'd1);
        chk({pfx, "_alu_ctrl"},   32'(bus.alu_ctrl),   32'd15);
        chk({pfx, "_alu_src1"},   bus.alu_src1,        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        logic [1:0] op;
        logic [5:0] f;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.req_aluop = '0;
        bus.req_funct = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk_reset_state("por");
        rst = 1'b0;
        tick();

        // Basic R-type add and the two-cycle latency
        send(2'b10, 6'b100000, 32'd5, 32'd7, 4'd3, acc);
        chk("add_acc",      32'(acc),           32'd1);
        chk("add_lat1_vld", 32'(bus.rsp_valid), 32'd0);
        chk("add_occ1",     32'(bus.occupancy), 32'd1);
        chk("add_alu_ctrl", 32'(bus.alu_ctrl),  32'd2);
        chk("add_alu_src1", bus.alu_src1,       32'd5);
        tick();
        chk("add_lat2_vld", 32'(bus.rsp_valid), 32'd1);
        chk("add_result",   bus.rsp_result,     32'd12);
        chk("add_tag",      32'(bus.rsp_tag),   32'd3);
        drain("drain_add");

        send(2'b01, 6'd0, 32'd9, 32'd9, 4'd4, acc);
        send(2'b11, 6'd0, 32'hFFFF_FFFF, 32'd1, 4'd5, acc);
        tick();
        chk("slt_result", bus.rsp_result,   32'd0);
        chk("slt_zero",   32'(bus.rsp_zero), 32'd1);
        drain("drain_sub_slt");

        // Backpressure: five requests fit (one response + four queued)
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            send(2'b00, 6'd0, 32'(t * 3), 32'd1, TAG_W'(t), acc);
            chk($sformatf("bp_acc%0d", t), 32'(acc), (t < 5) ? 32'd1 : 32'd0);
        end
        chk("bp_occ",       32'(bus.occupancy), 32'd4);
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_rsp_tag",   32'(bus.rsp_tag),   32'd0);
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("bp_out_vld%0d", t), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp_out_tag%0d", t), 32'(bus.rsp_tag),   32'(t));
            tick();
        end
        send(2'b00, 6'd0, 32'd100, 32'd1, 4'd5, acc);
        chk("bp_tag5_acc", 32'(acc), 32'd1);
        drain("drain_bp");

        // Illegal funct flows through as an error response
        send(2'b10, 6'b000011, 32'd11, 32'd22, 4'd9, acc);
        chk("ill_alu_ctrl", 32'(bus.alu_ctrl), 32'd15);
        send(2'b10, 6'b100101, 32'h0F0, 32'h00F, 4'd10, acc);
        drain("drain_ill");

        // Sustained traffic with a ready consumer
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = funct_tbl[$urandom_range(0, 8)];
            send(op, f, $urandom, (i % 4 == 0) ? 32'd0 : $urandom, TAG_W'(i), acc);
            chk($sformatf("str_acc%0d", i), 32'(acc), 32'd1);
            chk($sformatf("str_occ%0d", i), 32'(bus.occupancy <= 1), 32'd1);
        end
        drain("drain_stream");

        // Reset mid-stream discards queued work and the pending response
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 6'd0, 32'(i + 1), 32'd1, TAG_W'(i + 6), acc);
        end
        chk("mid_occ",       32'(bus.occupancy), 32'd3);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        sb.delete();
        tick();
        chk_reset_state("mid_rst");
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_vld%0d", i), 32'(bus.rsp_valid), 32'd0);
        end
        send(2'b00, 6'd0, 32'd40, 32'd2, 4'd1, acc);
        chk("post_rst_acc", 32'(acc), 32'd1);
        drain("drain_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
